// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM state
// encodings and the common data-bus width.
package mult_div_unit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    MD_OP_MULT  = 2'b00,
    MD_OP_MULTU = 2'b01,
    MD_OP_DIV   = 2'b10,
    MD_OP_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_MUL  = 3'd1,
    MD_DIV  = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_t;

  function automatic logic is_div_op(input md_op_t op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Radix-2 restoring divider datapath: one quotient bit per step on unsigned
// operands, with a step counter that saturates at the final step.
module div_radix2_core
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] divr;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // NOTE: combinational logic uses blocking assignments so each line sees the
  // value computed just above it; registers below use non-blocking only.
  always_comb begin
    rem_sh = {remainder, quotient[WIDTH-1]};
    diff   = rem_sh - {1'b0, divr};
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      divr      <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (load) begin
      cnt       <= '0;
      divr      <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (step) begin
      // A non-negative trial difference means the divisor fits: keep it, emit a 1.
      if (!diff[WIDTH]) begin
        remainder <= diff[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        remainder <= rem_sh[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end
      if (!last) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit feeding the HI/LO pair. Owns the FSM,
// the signed/unsigned operand handling and the pipelined multiply path.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int DATA_WIDTH  = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic                  hilo_write_en,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out
);

  localparam int PW = 2 * DATA_WIDTH;

  md_state_t             state;
  md_op_t                op_in;
  md_op_t                op_q;
  logic [DATA_WIDTH-1:0] a_raw;
  logic                  q_neg;
  logic                  r_neg;
  logic                  div_zero;
  logic [1:0]            mul_cnt;
  logic [PW-1:0]         mul_pipe [MUL_LATENCY];

  logic                  accept;
  logic                  signed_div;
  logic                  mul_sx;
  logic [PW-1:0]         ext_a;
  logic [PW-1:0]         ext_b;
  logic [PW-1:0]         product;
  logic [DATA_WIDTH-1:0] a_abs;
  logic [DATA_WIDTH-1:0] b_abs;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  div_last;
  logic [DATA_WIDTH-1:0] q_fix;
  logic [DATA_WIDTH-1:0] r_fix;

  assign op_in      = md_op_t'(op);
  assign accept     = (state == MD_IDLE) && start && !flush;
  assign signed_div = (op_in == MD_OP_DIV);
  assign mul_sx     = (op_in == MD_OP_MULT);

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both signed and unsigned operands.
  assign ext_a   = {{DATA_WIDTH{mul_sx & operand_a[DATA_WIDTH-1]}}, operand_a};
  assign ext_b   = {{DATA_WIDTH{mul_sx & operand_b[DATA_WIDTH-1]}}, operand_b};
  assign product = ext_a * ext_b;

  assign a_abs = (signed_div && operand_a[DATA_WIDTH-1]) ? ('0 - operand_a) : operand_a;
  assign b_abs = (signed_div && operand_b[DATA_WIDTH-1]) ? ('0 - operand_b) : operand_b;

  div_radix2_core #(.WIDTH(DATA_WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && is_div_op(op_in)),
    .step      (state == MD_DIV),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .quotient  (quotient),
    .remainder (remainder),
    .last      (div_last)
  );

  // Zero divisor bypasses the sign fix-up so hi returns the raw dividend.
  always_comb begin
    q_fix = quotient;
    r_fix = remainder;
    if (div_zero) begin
      q_fix = '1;
      r_fix = a_raw;
    end else if (op_q == MD_OP_DIV) begin
      if (q_neg) q_fix = '0 - quotient;
      if (r_neg) r_fix = '0 - remainder;
    end
  end

  assign hilo_write_en = done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MD_IDLE;
      op_q     <= MD_OP_MULT;
      a_raw    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      mul_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      // NOTE: the product delay chain is cleared on reset so no stale operand
      // data survives; it is small enough to be plain flops, not a RAM.
      for (int i = 0; i < MUL_LATENCY; i++) mul_pipe[i] <= '0;
    end else begin
      done <= 1'b0;
      if (state == MD_MUL) begin
        for (int i = 1; i < MUL_LATENCY; i++) mul_pipe[i] <= mul_pipe[i-1];
      end

      if (flush) begin
        state <= MD_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          MD_IDLE: begin
            if (start) begin
              op_q  <= op_in;
              a_raw <= operand_a;
              busy  <= 1'b1;
              if (is_div_op(op_in)) begin
                q_neg    <= operand_a[DATA_WIDTH-1] ^ operand_b[DATA_WIDTH-1];
                r_neg    <= operand_a[DATA_WIDTH-1];
                div_zero <= (operand_b == '0);
                state    <= MD_DIV;
              end else begin
                mul_pipe[0] <= product;
                mul_cnt     <= '0;
                state       <= MD_MUL;
              end
            end
          end
          MD_MUL: begin
            if (mul_cnt == 2'(MUL_LATENCY - 1)) begin
              hi_out <= mul_pipe[MUL_LATENCY-1][PW-1:DATA_WIDTH];
              lo_out <= mul_pipe[MUL_LATENCY-1][DATA_WIDTH-1:0];
              done   <= 1'b1;
              state  <= MD_DONE;
            end else begin
              mul_cnt <= mul_cnt + 2'd1;
            end
          end
          MD_DIV: begin
            if (div_last) state <= MD_FIX;
          end
          MD_FIX: begin
            hi_out <= r_fix;
            lo_out <= q_fix;
            done   <= 1'b1;
            state  <= MD_DONE;
          end
          MD_DONE: begin
            state <= MD_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= MD_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, results, flush, reset and
// the single-cycle HI/LO write pulse.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        hilo_write_en;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int vectors     = 0;
  int miscompares = 0;
  int consec_done = 0;
  int hwe_diff    = 0;
  logic prev_done = 1'b0;

  mult_div_unit dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .op            (op),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .flush         (flush),
    .busy          (busy),
    .done          (done),
    .hilo_write_en (hilo_write_en),
    .hi_out        (hi_out),
    .lo_out        (lo_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1 && prev_done === 1'b1) consec_done++;
    if (hilo_write_en !== done) hwe_diff++;
    prev_done = done;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one op; optionally pulses a decoy start in cycle noise_cyc.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int noise_cyc, output int done_cyc, output int busy_cnt,
                        output int pulses, output logic busy_after);
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = 0; busy_cnt = 0; pulses = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == noise_cyc) begin
        op = MD_OP_MULTU; operand_a = 32'd3; operand_b = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = cyc;
        pulses++;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    if (done) pulses++;
    busy_after = busy;
  endtask

  task automatic do_vec(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int noise_cyc, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int dc, bc, pc;
    logic ba;
    run_op(o, a, b, noise_cyc, dc, bc, pc, ba);
    check({tag, "_done_cycle"}, 64'(dc), 64'(exp_cyc));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_cyc));
    check({tag, "_pulses"}, 64'(pc), 64'd1);
    check({tag, "_busy_after"}, 64'(ba), 64'd0);
    check({tag, "_hi"}, 64'(hi_out), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo_out), 64'(exp_lo));
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
    operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hwe",  64'(hilo_write_en), 64'd0);
    check("rst_hi",   64'(hi_out), 64'd0);
    check("rst_lo",   64'(lo_out), 64'd0);
    rst = 1'b0;

    do_vec("multu_max", MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3, 32'hFFFF_FFFE, 32'h0000_0001);
    do_vec("mult_neg",  MD_OP_MULT,  32'hFFFF_FFFE, 32'd3,         3, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_vec("divu_100_7", MD_OP_DIVU, 32'd100,       32'd7,         5, 34, 32'd2,        32'h0000_000E);
    do_vec("div_neg7_2", MD_OP_DIV,  32'hFFFF_FFF9, 32'd2,         0, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_vec("div_ovf",    MD_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 34, 32'h0,        32'h8000_0000);
    do_vec("divu_zero",  MD_OP_DIVU, 32'h0000_1234, 32'd0,         0, 34, 32'h0000_1234, 32'hFFFF_FFFF);
    do_vec("div_zero",   MD_OP_DIV,  32'hFFFF_FFF8, 32'd0,        34, 34, 32'hFFFF_FFF8, 32'hFFFF_FFFF);

    // Flush in cycle 10 of a DIVU: idle next cycle, no write, HI/LO kept.
    @(negedge clk);
    op = MD_OP_DIVU; operand_a = 32'd50; operand_b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("flush_pulses", 64'(pulses), 64'd0);
    check("flush_hi", 64'(hi_out), 64'hFFFF_FFF8);
    check("flush_lo", 64'(lo_out), 64'hFFFF_FFFF);
    do_vec("multu_6_7", MD_OP_MULTU, 32'd6, 32'd7, 0, 3, 32'd0, 32'd42);

    // Reset in cycle 20 of a DIV with decoy starts while busy.
    @(negedge clk);
    op = MD_OP_DIV; operand_a = 32'hFFFF_FF9C; operand_b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (done) pulses++;
      start = (cyc == 5 || cyc == 12);
      if (cyc == 20) rst = 1'b1;
    end
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_hwe",  64'(hilo_write_en), 64'd0);
    check("rst_mid_hi",   64'(hi_out), 64'd0);
    check("rst_mid_lo",   64'(lo_out), 64'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("rst_mid_pulses", 64'(pulses), 64'd0);

    check("done_consecutive", 64'(consec_done), 64'd0);
    check("hwe_eq_done",      64'(hwe_diff), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle integer multiply/divide unit for the MIPS core. It sits in the execute stage directly upstream of the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU with two 32-bit operands and produces the 64-bit {hi, lo} result. On completion it drives the HI/LO write enable for exactly one cycle. It stalls the pipeline through busy while an operation is in flight.

Parameters:
- MUL_LATENCY, 2, cycles spent in MUL state (1..4). The product is computed on operand latch and carried through a delay register chain.
- DATA_WIDTH, 32, operand and result width. Only 32 is supported; it matches the shared data bus width.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- op  input  2  operation code, see shared header
- operand_a  input  32  rs: multiplicand, or dividend
- operand_b  input  32  rt: multiplier, or divisor
- flush  input  1  cancel any in-flight operation; no HI/LO write
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse when the result is valid
- hilo_write_en  output  1  identical to done; drives the HI/LO write enable
- hi_out  output  32  product[63:32], or remainder
- lo_out  output  32  product[31:0], or quotient

Behaviour:
- Reset (rst=1 at a clock edge) applies from any state, mid-operation included.
  - State goes to IDLE.
  - busy, done, hilo_write_en = 0.
  - hi_out, lo_out = 0.
  - Counter and internal operands are cleared.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE with start=1 and flush=0 (cycle 0):
  - Latch op and both operands.
  - MULT/MULTU: go to MUL.
  - DIV/DIVU: go to DIV with counter=0. For DIV, latch the absolute values and record the sign of the quotient (sign_a XOR sign_b) and of the remainder (sign_a).
- MUL: stays MUL_LATENCY cycles.
  - MULT uses a signed 64-bit product; MULTU uses an unsigned one.
  - Then go to DONE. With the default, done is asserted in cycle 3.
- DIV: radix-2 restoring division, one quotient bit per cycle, 32 cycles (cycles 1..32). Counter runs 0..31 and must not wrap.
- FIX (cycle 33): for DIV, negate quotient and remainder per the recorded signs. DIVU passes through.
- DONE (cycle 34 for divide):
  - done = hilo_write_en = 1 for exactly one cycle; hi_out and lo_out are valid.
  - Next state is IDLE.
  - A start in the DONE cycle is ignored; the requester must wait for busy=0.
- hi_out and lo_out are updated only on entry to DONE and hold their value until the next completion or reset.
- start while busy=1: ignored. No queuing.
- flush=1: next state is IDLE from any state, and no write occurs.
  - flush has priority over start in the same cycle.
  - flush in the DONE cycle does not suppress the pulse already being driven.
  - hi_out and lo_out keep their previous values.
- Divide by zero (operand_b=0), DIV or DIVU: normal latency, lo_out = 0xFFFFFFFF, hi_out = operand_a as latched (raw).
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo_out = 0x80000000, hi_out = 0. This falls out of the abs/negate path and needs no special case.
- Invariants the bench must check:
  - done and hilo_write_en are never high in two consecutive cycles.
  - busy=0 exactly when the state is IDLE.

Decomposition:
- Shared header bus.v gains:
  - MD_OP_MULT=2'b00, MD_OP_MULTU=2'b01, MD_OP_DIV=2'b10, MD_OP_DIVU=2'b11.
  - The MD state encodings.
  - It reuses the existing DATA_BUS define for all 32-bit ports.
- One sub-module, div_radix2_core, holds the 32-step restoring shift/subtract datapath and the counter. mult_div_unit owns the FSM, the sign handling and the multiply path.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done in cycle 3, hi_out=0xFFFFFFFE, lo_out=0x00000001, hilo_write_en high for 1 cycle.
- MULT a=0xFFFFFFFE(-2) b=3 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFA; busy high during cycles 1..3.
- DIVU a=100 b=7 -> done in cycle 34, lo_out=0x0000000E, hi_out=0x00000002. DIV a=0xFFFFFFF9(-7) b=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0. DIVU a=0x1234 b=0 -> lo_out=0xFFFFFFFF, hi_out=0x00001234.
- DIVU started, flush=1 at cycle 10 -> busy=0 at cycle 11, no done pulse, hi/lo unchanged. A new MULTU 6*7 then gives lo_out=42, hi_out=0.
- rst=1 at cycle 20 of a DIV, plus start pulses while busy -> all outputs 0 after reset. Starts while busy are ignored, with no second done pulse.
